// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline control blocks.
//   - state_t   : hazard controller FSM encoding (RUN=0, SQUASH=1)
//   - REG_IDX_W : register-index width
//   - ZERO_REG  : index of the hard-wired zero register
package mips_pipe_pkg;

    localparam int unsigned REG_IDX_W = 5;

    localparam logic [REG_IDX_W-1:0] ZERO_REG = '0;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SQUASH = 1'b1
    } state_t;

endpackage : mips_pipe_pkg

// File: rtl/hazard_perf_cnt.sv
// Saturating performance counter with increment enable.
//   clk, reset : clock, asynchronous active-high reset
//   inc        : count this cycle
//   count      : current value, sticks at all-ones
module hazard_perf_cnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule : hazard_perf_cnt

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, memory-busy freeze and
// branch/jump redirect with a post-redirect IF/ID squash window.
// Optional feature macro: HAZARD_PERF_CNT_EN builds the performance counters;
// without it the cnt_* outputs are tied to zero.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   id_rs, id_rt          : source fields of the instruction in ID
//   id_uses_rt            : ID instruction reads rt
//   ex_MemRead, ex_rt     : load indication and destination of the EX instruction
//   ex_redirect           : taken branch / jump resolved in EX
//   mem_busy              : data memory not ready, freeze front end
//   pc_write, if_id_write : front-end load enables (combinational)
//   if_id_flush           : IF/ID clear (combinational)
//   id_ex_stall/flush     : ID/EX controls (combinational)
//   busy_squash           : in the squash window
//   cnt_load_use/redirect/freeze : saturating event counters
module hazard_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int unsigned EXTRA_SQUASH = 0,
    parameter int unsigned CNT_W        = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_IDX_W-1:0] id_rs,
    input  logic [REG_IDX_W-1:0] id_rt,
    input  logic                 id_uses_rt,
    input  logic                 ex_MemRead,
    input  logic [REG_IDX_W-1:0] ex_rt,
    input  logic                 ex_redirect,
    input  logic                 mem_busy,
    output logic                 pc_write,
    output logic                 if_id_write,
    output logic                 if_id_flush,
    output logic                 id_ex_stall,
    output logic                 id_ex_flush,
    output logic                 busy_squash,
    output logic [CNT_W-1:0]     cnt_load_use,
    output logic [CNT_W-1:0]     cnt_redirect,
    output logic [CNT_W-1:0]     cnt_freeze
);

    localparam logic [2:0] SQ_RELOAD = 3'(EXTRA_SQUASH);

    state_t     state_q, state_d;
    logic [2:0] sq_cnt_q, sq_cnt_d;
    logic       load_use;

    // Register 0 is never a real dependency.
    assign load_use = ex_MemRead && (ex_rt != ZERO_REG) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_RUN;
            sq_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            sq_cnt_q <= sq_cnt_d;
        end
    end

    // Next state and prioritised control outputs.
    always_comb begin
        state_d     = state_q;
        sq_cnt_d    = sq_cnt_q;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_stall = 1'b0;
        id_ex_flush = 1'b0;
        busy_squash = (state_q == ST_SQUASH);

        if (reset) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            busy_squash = 1'b0;
        end else if (mem_busy) begin
            // EX inputs are held by the stalled ID/EX, so pending events
            // are simply re-evaluated once the freeze lifts.
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_stall = 1'b1;
        end else if (ex_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            if (EXTRA_SQUASH > 0) begin
                state_d  = ST_SQUASH;
                sq_cnt_d = SQ_RELOAD;
            end else begin
                state_d  = ST_RUN;
                sq_cnt_d = '0;
            end
        end else if (load_use) begin
            // Bubble; squash window, if any, pauses for this cycle.
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end else if (state_q == ST_SQUASH) begin
            if_id_flush = 1'b1;
            sq_cnt_d    = sq_cnt_q - 3'd1;
            if (sq_cnt_q <= 3'd1) begin
                state_d  = ST_RUN;
                sq_cnt_d = '0;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic inc_freeze, inc_redirect, inc_load_use;

    assign inc_freeze   = !reset && mem_busy;
    assign inc_redirect = !reset && !mem_busy && ex_redirect;
    assign inc_load_use = !reset && !mem_busy && !ex_redirect && load_use;

    hazard_perf_cnt #(.CNT_W(CNT_W)) u_cnt_load_use (
        .clk(clk), .reset(reset), .inc(inc_load_use), .count(cnt_load_use)
    );
    hazard_perf_cnt #(.CNT_W(CNT_W)) u_cnt_redirect (
        .clk(clk), .reset(reset), .inc(inc_redirect), .count(cnt_redirect)
    );
    hazard_perf_cnt #(.CNT_W(CNT_W)) u_cnt_freeze (
        .clk(clk), .reset(reset), .inc(inc_freeze), .count(cnt_freeze)
    );
`else
    assign cnt_load_use = '0;
    assign cnt_redirect = '0;
    assign cnt_freeze   = '0;
`endif

endmodule : hazard_ctrl

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core. It generates the `stall` and `flush` controls consumed by the ID/EX register, plus the PC and IF/ID write/flush enables. It sits between ID and EX. It detects load-use hazards, memory-busy freezes and taken branch/jump redirects, and sequences a configurable post-redirect squash window.

## Interface
- `EXTRA_SQUASH`, default 0: IF/ID squash cycles after a redirect, beyond the redirect cycle itself. Range 0–7.
- `CNT_W`, default 32: width of the performance counters.

- `clk`, input, 1: clock.
- `reset`, input, 1: reset, asynchronous, active-high.
- `id_rs`, input, 5: rs field of the instruction in ID.
- `id_rt`, input, 5: rt field of the instruction in ID.
- `id_uses_rt`, input, 1: the ID instruction reads rt as a source.
- `ex_MemRead`, input, 1: MemRead of the instruction in EX (ID/EX output).
- `ex_rt`, input, 5: rt of the instruction in EX.
- `ex_redirect`, input, 1: branch taken or jump resolved in EX this cycle.
- `mem_busy`, input, 1: data memory is not ready; the whole front end must freeze.
- `pc_write`, output, 1: PC update enable.
- `if_id_write`, output, 1: IF/ID load enable.
- `if_id_flush`, output, 1: IF/ID clear.
- `id_ex_stall`, output, 1: drives the ID/EX `stall` input.
- `id_ex_flush`, output, 1: drives the ID/EX `flush` input.
- `busy_squash`, output, 1: high while in SQUASH state.
- `cnt_load_use`, output, CNT_W: number of load-use bubbles inserted.
- `cnt_redirect`, output, CNT_W: number of redirects taken.
- `cnt_freeze`, output, CNT_W: number of `mem_busy` cycles.

## Operation
- The FSM has two states: RUN and SQUASH. There is also a 3-bit down-counter `sq_cnt`.
- Control outputs are combinational from the state and the inputs, so they act in the same cycle. Priority, highest first:
  1. **Freeze.** When `mem_busy`=1: pc_write=0, if_id_write=0, id_ex_stall=1, both flushes=0. The state and `sq_cnt` hold. A redirect or load-use hazard present during a freeze is ignored; it is re-evaluated when the freeze ends, because the EX inputs are held stable by the stalled ID/EX.
  2. **Redirect.** When `ex_redirect`=1 in any state: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_flush=1, id_ex_stall=0.
     - If EXTRA_SQUASH>0, the next state is SQUASH with `sq_cnt`=EXTRA_SQUASH.
     - Otherwise the next state is RUN.
  3. **Load-use.** When `ex_MemRead` && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)): pc_write=0, if_id_write=0, id_ex_flush=1, id_ex_stall=0. This inserts one bubble. It self-clears the next cycle because the bubble has MemRead=0.
  4. **SQUASH, no other event.** pc_write=1, if_id_write=1, if_id_flush=1, id_ex_flush=0. `sq_cnt` decrements; on the transition 1→0 the state goes to RUN.
  5. **RUN, no event.** pc_write=1, if_id_write=1, all flush and stall outputs 0.
- Register 0 never creates a hazard. ex_rt==0 with MemRead=1 produces no stall.
- A redirect while in SQUASH reloads `sq_cnt` to EXTRA_SQUASH.

## Timing
- While `reset`=1: state=RUN, sq_cnt=0, all counters 0.
  - Forced outputs: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1, id_ex_stall=0, busy_squash=0.
- After reset deasserts: RUN behaviour applies from the first clock edge.
- Reset asserted mid-SQUASH aborts the window immediately.
- Control outputs have zero-cycle latency: they are combinational.
- State, counter and perf updates take effect at the clock edge.
- Redirect penalty is 2 + EXTRA_SQUASH squashed slots.
- Counters saturate at all-ones; they do not wrap.
- Counter increments, each once per qualifying cycle:
  - `cnt_freeze`: every `mem_busy` cycle.
  - `cnt_redirect`: every non-frozen redirect cycle.
  - `cnt_load_use`: every cycle in which the load-use rule wins.

## Configuration
- `HAZARD_PERF_CNT_EN` defined: the three counters exist and behave as specified.
- `HAZARD_PERF_CNT_EN` undefined: no counter flops are built and `cnt_*` outputs are tied to 0. Control behaviour is identical in both cases.

## Structure
- The shared package `mips_pipe_pkg` holds:
  - the FSM state encoding (RUN=0, SQUASH=1);
  - the register-index width (5);
  - the zero-register constant.
- One sub-module, `hazard_perf_cnt`: a saturating CNT_W-bit counter with an increment enable. It is instantiated three times, inside the `HAZARD_PERF_CNT_EN` guard.

## Test plan
- **Load-use.** lw r5 in EX (ex_MemRead=1, ex_rt=5), ID id_rs=5.
  - Same cycle: pc_write=0, if_id_write=0, id_ex_flush=1.
  - Next cycle (ex_MemRead=0): all enables 1; cnt_load_use=1.
- **No false hazard.** ex_MemRead=1, ex_rt=0, id_rs=0 → no stall. Also ex_rt=7, id_rt=7, id_uses_rt=0 → no stall.
- **Redirect with EXTRA_SQUASH=2.** One pulse of ex_redirect → flush both registers for 1 cycle, then if_id_flush=1 for exactly 2 cycles with busy_squash=1, then RUN; cnt_redirect=1.
- **Freeze priority.** mem_busy=1 for 3 cycles while ex_redirect=1.
  - Those 3 cycles: id_ex_stall=1, no flush, pc_write=0.
  - Cycle 4: redirect flush fires; cnt_freeze=3.
- **Reset mid-SQUASH.** Assert reset asynchronously during the squash window → outputs go to their reset values immediately; after release, RUN with sq_cnt=0.
- **Saturation.** With CNT_W=4 and `HAZARD_PERF_CNT_EN` defined, 20 freeze cycles → cnt_freeze=15.
  - Rerun without the macro → all cnt_* = 0 and control trace is identical.
